// File: rtl/tile_pkg.sv
// Shared tile fetch types and widths: word address, pixel and palette widths,
// fetch FSM state encoding, and the nibble-reversal helper used for flip_x.
package tile_pkg;
  localparam int TILE_ADDR_W = 18;
  localparam int PIX_W       = 4;
  localparam int PAL_W       = 6;
  localparam int NPIX        = 8;
  localparam int WORD_W      = NPIX * PIX_W;
  localparam int X_W         = 3;

  typedef enum logic [1:0] {IDLE, REQ, SHIFT, GAP} fetch_state_t;

  // Reverse nibble order so a flipped row can use the same MSB-first shifter
  function automatic logic [WORD_W-1:0] flip_nibbles(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < NPIX; i++)
      r[i*PIX_W +: PIX_W] = w[(NPIX-1-i)*PIX_W +: PIX_W];
    return r;
  endfunction
endpackage

// File: rtl/tile_pix_shift.sv
// Pixel serializer for one tile row: holds the fetched word (pre-flipped on
// load), always presents the top nibble, and counts pix_x in output order.
module tile_pix_shift
  import tile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [WORD_W-1:0]      load_data,
  input  logic                   load_flip,
  input  logic [PAL_W-1:0]       load_palette,
  input  logic                   advance,
  output logic [PAL_W+PIX_W-1:0] pix_data,
  output logic [X_W-1:0]         pix_x,
  output logic                   pix_opaque,
  output logic                   nib_zero,
  output logic                   last
);
  logic [WORD_W-1:0] sr;
  logic [PAL_W-1:0]  pal;
  logic [PIX_W-1:0]  nib;

  // Load a new row or shift out one nibble per consumed transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      pal   <= '0;
      pix_x <= '0;
    end else if (load) begin
      sr    <= load_flip ? flip_nibbles(load_data) : load_data;
      pal   <= load_palette;
      pix_x <= '0;
    end else if (advance) begin
      sr    <= {sr[WORD_W-PIX_W-1:0], {PIX_W{1'b0}}};
      pix_x <= pix_x + 3'd1;
    end
  end

  assign nib        = sr[WORD_W-1 -: PIX_W];
  assign pix_data   = {pal, nib};
  assign pix_opaque = |nib;
  assign nib_zero   = ~|nib;
  assign last       = (pix_x == 3'd7);
endmodule

// File: rtl/tile_fetch.sv
// Tile row fetcher: requests one 32-bit word from tile_cache, then streams its
// eight 4bpp pixels with a valid/ready handshake.
// Optional build macro TILE_FETCH_SKIP_TRANSPARENT_EN: index-0 pixels are
// consumed internally in one cycle without asserting pix_valid.
module tile_fetch
  import tile_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [14:0]            tile_code,
  input  logic [2:0]             tile_row,
  input  logic                   flip_x,
  input  logic [PAL_W-1:0]       palette,
  output logic                   busy,
  output logic                   done,
  output logic                   cache_req,
  output logic [TILE_ADDR_W-1:0] cache_addr,
  input  logic                   cache_valid,
  input  logic [WORD_W-1:0]      cache_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [PAL_W+PIX_W-1:0] pix_data,
  output logic [X_W-1:0]         pix_x,
  output logic                   pix_opaque
);
  fetch_state_t     state, state_nx;
  logic             load, advance, last, nib_zero, flip_q;
  logic [PAL_W-1:0] pal_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Capture request parameters when a start is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_addr <= '0;
      flip_q     <= 1'b0;
      pal_q      <= '0;
    end else if (state == IDLE && start) begin
      cache_addr <= {tile_code, tile_row};
      flip_q     <= flip_x;
      pal_q      <= palette;
    end
  end

  // Next state and handshake decode; cache_req is low outside REQ, so it
  // always drops for the whole SHIFT/GAP/IDLE stretch between requests
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    advance   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cache_req = 1'b0;
    pix_valid = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = REQ;
      end
      REQ: begin
        cache_req = 1'b1;
        if (cache_valid) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
`ifdef TILE_FETCH_SKIP_TRANSPARENT_EN
        pix_valid = ~nib_zero;
        advance   = pix_ready | nib_zero;
`else
        pix_valid = 1'b1;
        advance   = pix_ready;
`endif
        if (advance && last) state_nx = GAP;
      end
      GAP: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  tile_pix_shift u_shift (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .load_data    (cache_data),
    .load_flip    (flip_q),
    .load_palette (pal_q),
    .advance      (advance),
    .pix_data     (pix_data),
    .pix_x        (pix_x),
    .pix_opaque   (pix_opaque),
    .nib_zero     (nib_zero),
    .last         (last)
  );
endmodule
